// File: rtl/irdy_trdy_window_ctrl.sv
// Drives the active-low irdy/trdy pair as a bounded transfer window.
// irdy stays low for win_len+1 cycles, and trdy is low for a contiguous run inside that window.
module irdy_trdy_window_ctrl #(
  parameter int WIN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [WIN_W-1:0] trdy_off,
  input  logic [WIN_W-1:0] trdy_len,
  output logic             irdy,
  output logic             trdy,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER} state_t;

  state_t           state;
  logic [WIN_W-1:0] cnt;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] off_q;
  logic [WIN_W-1:0] tlen_q;

  // Sums are one bit wider so that off+len never wraps at the top of the range.
  function automatic logic cfg_ok(input logic [WIN_W-1:0] wl,
                                  input logic [WIN_W-1:0] off,
                                  input logic [WIN_W-1:0] tl);
    logic [WIN_W:0] sum;
    logic [WIN_W:0] lim;
    sum = {1'b0, off} + {1'b0, tl};
    lim = {1'b0, wl} + (WIN_W+1)'(1);
    return (wl != '0) && (tl != '0) && (sum <= lim);
  endfunction

  function automatic logic trdy_low(input logic [WIN_W-1:0] c,
                                    input logic [WIN_W-1:0] off,
                                    input logic [WIN_W-1:0] tl);
    logic [WIN_W:0] end_x;
    end_x = {1'b0, off} + {1'b0, tl};
    return (c >= off) && ({1'b0, c} < end_x);
  endfunction

  // The config latch carries no reset: it is only read while ACTIVE.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      len_q  <= win_len;
      off_q  <= trdy_off;
      tlen_q <= trdy_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      irdy    <= 1'b1;
      trdy    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok(win_len, trdy_off, trdy_len)) begin
              state <= ACTIVE;
              cnt   <= '0;
              irdy  <= 1'b0;
              trdy  <= ~trdy_low('0, trdy_off, trdy_len);
              busy  <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          // abort wins over the natural end so that aborted is reported even on the last cycle.
          if (abort || cnt == len_q) begin
            state   <= RECOVER;
            irdy    <= 1'b1;
            trdy    <= 1'b1;
            done    <= 1'b1;
            aborted <= abort;
          end else begin
            cnt  <= cnt + WIN_W'(1);
            trdy <= ~trdy_low(cnt + WIN_W'(1), off_q, tlen_q);
          end
        end
        RECOVER: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          irdy  <= 1'b1;
          trdy  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irdy_trdy_window_ctrl.sv
// Bench for irdy_trdy_window_ctrl: table of window programs with per-cycle expectations
// pushed to a scoreboard queue, plus hand-written reset and idle-abort sequences.
module tb_irdy_trdy_window_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] win_len;
  logic [W-1:0] trdy_off;
  logic [W-1:0] trdy_len;
  logic         irdy;
  logic         trdy;
  logic         busy;
  logic         done;
  logic         aborted;
  logic         cfg_err;

  irdy_trdy_window_ctrl #(.WIN_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .win_len(win_len), .trdy_off(trdy_off), .trdy_len(trdy_len),
    .irdy(irdy), .trdy(trdy), .busy(busy), .done(done),
    .aborted(aborted), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  logic [5:0] sbq[$];

  localparam logic [5:0] IDLE_EXP = 6'b110000;  // {irdy,trdy,busy,done,aborted,cfg_err}

  // trdy low while irdy is high means the run escaped the window.
  assert property (@(posedge clk) disable iff (rst) (!trdy |-> !irdy));
  always @(negedge clk) if (!rst && trdy === 1'b0 && irdy !== 1'b0) viol++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] exp, input string name);
    logic [5:0] e;
    sbq.push_back(exp);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk(name, int'({irdy, trdy, busy, done, aborted, cfg_err}), int'(e));
  endtask

  typedef struct {
    int wl; int off; int len; int abort_at; bit extra; bit valid; int low;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int e_end;
    bit ab;
    int low;
    logic [5:0] exp;
    ab    = (v.abort_at >= 0) && (v.abort_at <= v.wl);
    e_end = ab ? v.abort_at : v.wl;
    start = 1'b1; abort = 1'b0;
    win_len = W'(v.wl); trdy_off = W'(v.off); trdy_len = W'(v.len);
    if (!v.valid) begin
      step(6'b110001, $sformatf("v%0d_cfg_err", idx));
      start = 1'b0;
      step(IDLE_EXP, $sformatf("v%0d_idle_after_err", idx));
      return;
    end
    low = 0;
    for (int k = 0; k <= e_end + 2; k++) begin
      if (k > 0) begin
        start = v.extra;
        win_len = W'($urandom); trdy_off = W'($urandom); trdy_len = W'($urandom);
        abort = (ab && k == e_end + 1) || (v.extra && k == e_end + 2);
      end
      if (k <= e_end)
        exp = {1'b0, (k >= v.off && k < v.off + v.len) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      else if (k == e_end + 1)
        exp = {1'b1, 1'b1, 1'b1, 1'b1, ab, 1'b0};
      else
        exp = IDLE_EXP;
      step(exp, $sformatf("v%0d_k%0d", idx, k));
      if (irdy == 1'b0) low++;
    end
    start = 1'b0; abort = 1'b0;
    chk($sformatf("v%0d_irdy_low_cycles", idx), low, v.low);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8, 1, 7, -1, 1'b0, 1'b1, 9};    // reference program
    vecs[1]  = '{4, 3, 3, -1, 1'b0, 1'b0, 0};    // off+len 6 > 5
    vecs[2]  = '{0, 0, 1, -1, 1'b0, 1'b0, 0};    // win_len 0
    vecs[3]  = '{15, 0, 15, -1, 1'b0, 1'b1, 16}; // full range, no wrap
    vecs[4]  = '{8, 1, 7, 3, 1'b0, 1'b1, 4};     // abort at cycle 3
    vecs[5]  = '{3, 0, 1, -1, 1'b1, 1'b1, 4};    // starts while busy
    vecs[6]  = '{5, 2, 4, -1, 1'b0, 1'b1, 6};    // trdy through last cycle
    vecs[7]  = '{5, 0, 0, -1, 1'b0, 1'b0, 0};    // trdy_len 0
    vecs[8]  = '{15, 15, 1, -1, 1'b0, 1'b1, 16}; // sum exactly 16
    vecs[9]  = '{15, 15, 2, -1, 1'b0, 1'b0, 0};  // sum 17 must not wrap to valid
    vecs[10] = '{2, 1, 1, 2, 1'b0, 1'b1, 3};     // abort on the natural last cycle
    vecs[11] = '{8, 1, 7, -1, 1'b1, 1'b1, 9};    // back-to-back after busy starts

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    win_len = '0; trdy_off = '0; trdy_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({irdy, trdy, busy, done, aborted, cfg_err}), int'(IDLE_EXP));
    rst = 1'b0;

    // abort with nothing running changes nothing
    abort = 1'b1;
    step(IDLE_EXP, "abort_idle0");
    step(IDLE_EXP, "abort_idle1");
    abort = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // reset in the middle of a window
    start = 1'b1; win_len = 4'd8; trdy_off = 4'd1; trdy_len = 4'd7;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) start = 1'b0;
      step({1'b0, (k >= 1) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, $sformatf("rstwin_k%0d", k));
    end
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", int'({irdy, trdy, busy, done, aborted, cfg_err}), int'(IDLE_EXP));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold%0d", c), int'({irdy, trdy, busy, done, aborted, cfg_err}), int'(IDLE_EXP));
    end
    rst = 1'b0;
    run_vec(vecs[0], 100);

    chk("scoreboard_empty", sbq.size(), 0);
    chk("within_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/irdy_trdy_window_ctrl.md
Name: irdy_trdy_window_ctrl

Overview:
Sequencer that drives the active-low irdy/trdy handshake pair as a bounded transfer window. On a start request it drops irdy and holds it low for a programmed number of cycles. Inside that window it drops trdy for a programmed contiguous run, so every window satisfies "trdy low run within the irdy fall-plus-low window" by construction. It sits in front of the bus interface and feeds the assertion-checked irdy/trdy pins.

Parameters:
WIN_W, 4, width of the window, offset and length fields; maximum window length is 2**WIN_W-1.

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a window; sampled only in IDLE
abort  input  1  terminate an active window early
win_len  input  WIN_W  irdy low cycles after the fall cycle (N); must be >=1
trdy_off  input  WIN_W  window index of first trdy-low cycle; index 0 is the fall cycle
trdy_len  input  WIN_W  consecutive trdy-low cycles; must be >=1
irdy  output  1  active-low initiator ready
trdy  output  1  active-low target ready
busy  output  1  high in ACTIVE and RECOVER
done  output  1  one-cycle pulse at window end
aborted  output  1  qualifies done; high when the window ended by abort
cfg_err  output  1  one-cycle pulse when start is rejected for bad config

Behaviour:
- Reset (async, immediate):
  - State is IDLE; cycle counter is 0.
  - irdy=1, trdy=1, busy=0, done=0, aborted=0, cfg_err=0.
  - Reset asserted mid-window forces irdy/trdy high in the same cycle, with no done pulse.
- Config check at start, computed in WIN_W+1 bits, no wrap:
  - valid = (win_len>=1) && (trdy_len>=1) && (trdy_off+trdy_len <= win_len+1).
- States:
  - IDLE:
    - start && valid: latch the three config fields, clear the counter, go to ACTIVE.
    - start && !valid: pulse cfg_err next cycle and stay in IDLE.
  - ACTIVE:
    - irdy=0; the counter runs 0..N.
    - Counter value 0 is the $fell(irdy) cycle, so irdy is low N+1 cycles in total.
    - trdy=0 iff off <= cnt < off+len; otherwise trdy=1.
    - At cnt==N go to RECOVER.
  - RECOVER:
    - Exactly one cycle; irdy=1, trdy=1, done=1.
    - aborted=1 if entered via abort.
    - Always returns to IDLE.
- Latency:
  - start sampled in IDLE at edge t gives irdy=0 from t+1 through t+1+N.
  - done is at t+2+N; the earliest next accepted start is sampled at t+3+N.
  - Each irdy fall is therefore preceded by at least one irdy-high cycle.
- Outputs are registered; there are no combinational paths from inputs to irdy/trdy.
- start outside IDLE is ignored (no queueing, no cfg_err). Config inputs are ignored outside the IDLE start cycle.
- abort in ACTIVE:
  - Next cycle is RECOVER: irdy=1, trdy=1, done=1, aborted=1.
  - abort takes priority over the natural cnt==N end.
  - abort in IDLE or RECOVER has no effect.
- Boundaries:
  - N = 2**WIN_W-1 must not wrap the counter.
  - trdy_off=0 puts trdy low on the fall cycle itself.
  - trdy_off+trdy_len == N+1 holds trdy low through the last irdy-low cycle.
  - trdy never goes low while irdy is high.
- Reference program: win_len=8, trdy_off=1, trdy_len=7.
  - Gives irdy low for 9 cycles (fall + 8) and trdy low for window cycles 1..7.

Test Plan:
1. Reference program:
   - Stimulus: start at t with 8/1/7.
   - Response: irdy=0 at t+1..t+9; trdy=0 at t+2..t+8; done=1, aborted=0 at t+10; busy low at t+11.
   - The bench also binds the within-property and requires it to pass.
2. Config rejection:
   - Stimulus: win_len=4, off=3, len=3 (sum 6 > 5).
   - Response: cfg_err pulse one cycle; irdy/trdy stay 1; busy stays 0.
   - Stimulus: win_len=0.
   - Response: cfg_err.
3. Full-coverage edge:
   - Stimulus: win_len=15, off=0, len=15 (WIN_W=4).
   - Response: irdy low 16 cycles; trdy low for window cycles 0..14 and high on cycle 15; no counter wrap.
4. Abort:
   - Stimulus: 8/1/7 program, abort asserted at window cycle 3.
   - Response: next cycle irdy=1, trdy=1, done=1, aborted=1; IDLE the cycle after.
5. Start while busy:
   - Stimulus: second start pulses during ACTIVE and during RECOVER.
   - Response: both ignored, no cfg_err. A start sampled in the first IDLE cycle after RECOVER begins a new window, with irdy having been high for at least one cycle.
6. Reset mid-window:
   - Stimulus: rst asserted at window cycle 5 for 2 cycles.
   - Response: irdy=1, trdy=1, busy=0 immediately; no done pulse; after release, start is accepted normally.
